// File: rtl/neopixel_ctrl_arbiter.sv
// Two-requester, burst-granular arbiter for the neopixel control write port.
// Round-robin between bursts, out-of-range writes dropped, stalled bursts revoked.
module neopixel_ctrl_arbiter #(
    parameter int unsigned C_PIXELS  = 12,
    parameter int unsigned C_TIMEOUT = 1024
) (
    input  logic        ctrl_clock,
    input  logic        ctrl_reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_address,
    input  logic [31:0] req0_data,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_address,
    input  logic [31:0] req1_data,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        ctrl_write_en,
    output logic [31:0] ctrl_address,
    output logic [31:0] ctrl_write_data,
    input  logic        ctrl_ready,
    output logic        grant_id,
    output logic        busy,
    output logic [15:0] drop_count,
    output logic [15:0] timeout_count
);
    localparam int unsigned TW = $clog2(C_TIMEOUT + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic          prio;
    logic [TW-1:0] stall_cnt;
    logic          g_valid;
    logic          g_last;
    logic [31:0]   g_address;
    logic [31:0]   g_data;
    logic          accept;
    logic          in_range;

    assign req0_ready = busy & ctrl_ready & ~grant_id;
    assign req1_ready = busy & ctrl_ready & grant_id;

    always_comb begin
        g_valid   = req0_valid;
        g_last    = req0_last;
        g_address = req0_address;
        g_data    = req0_data;
        if (grant_id) begin
            g_valid   = req1_valid;
            g_last    = req1_last;
            g_address = req1_address;
            g_data    = req1_data;
        end
    end

    assign accept   = busy & ctrl_ready & g_valid;
    assign in_range = g_address < 32'(C_PIXELS);

    always_ff @(posedge ctrl_clock) begin
        if (ctrl_reset) begin
            state           <= IDLE;
            busy            <= 1'b0;
            grant_id        <= 1'b0;
            prio            <= 1'b0;
            stall_cnt       <= '0;
            ctrl_write_en   <= 1'b0;
            ctrl_address    <= '0;
            ctrl_write_data <= '0;
            drop_count      <= '0;
            timeout_count   <= '0;
        end else begin
            ctrl_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid | req1_valid) begin
                        // prio only decides a tie; a lone requester always wins
                        grant_id  <= (req0_valid & req1_valid) ? prio : req1_valid;
                        state     <= BURST;
                        busy      <= 1'b1;
                        stall_cnt <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        stall_cnt <= '0;
                        if (in_range) begin
                            ctrl_write_en   <= 1'b1;
                            ctrl_address    <= g_address;
                            ctrl_write_data <= g_data;
                        end else if (drop_count != '1) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        if (g_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            prio  <= ~grant_id;
                        end
                    end else if (!g_valid) begin
                        // backpressure with valid held is not a stall, so only !valid counts
                        if (stall_cnt == TW'(C_TIMEOUT - 1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            prio      <= ~grant_id;
                            stall_cnt <= '0;
                            if (timeout_count != '1)
                                timeout_count <= timeout_count + 16'd1;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neopixel_ctrl_arbiter.sv
// Directed self-checking bench for neopixel_ctrl_arbiter (C_PIXELS=12, C_TIMEOUT=16).
module tb_neopixel_ctrl_arbiter;
    logic        ctrl_clock = 1'b0;
    logic        ctrl_reset;
    logic        req0_valid, req1_valid, req0_last, req1_last;
    logic [31:0] req0_address, req1_address, req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        ctrl_write_en, ctrl_ready, grant_id, busy;
    logic [31:0] ctrl_address, ctrl_write_data;
    logic [15:0] drop_count, timeout_count;

    int checks = 0;
    int errors = 0;

    neopixel_ctrl_arbiter #(.C_PIXELS(12), .C_TIMEOUT(16)) dut (
        .ctrl_clock(ctrl_clock), .ctrl_reset(ctrl_reset),
        .req0_valid(req0_valid), .req0_address(req0_address), .req0_data(req0_data),
        .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_address(req1_address), .req1_data(req1_data),
        .req1_last(req1_last), .req1_ready(req1_ready),
        .ctrl_write_en(ctrl_write_en), .ctrl_address(ctrl_address),
        .ctrl_write_data(ctrl_write_data), .ctrl_ready(ctrl_ready),
        .grant_id(grant_id), .busy(busy),
        .drop_count(drop_count), .timeout_count(timeout_count)
    );

    always #5 ctrl_clock = ~ctrl_clock;

    task automatic step();
        @(posedge ctrl_clock);
        #1;
    endtask

    task automatic do_reset();
        ctrl_reset = 1'b1;
        ctrl_ready = 1'b1;
        req0_valid = 1'b0; req0_address = '0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_address = '0; req1_data = '0; req1_last = 1'b0;
        step();
        ctrl_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ctrl_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %0h exp 0", ctrl_write_en); end
        checks++; if (ctrl_address !== 32'd0) begin errors++; $display("FAIL reset_addr: got %0h exp 0", ctrl_address); end
        checks++; if (ctrl_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h exp 0", ctrl_write_data); end
        checks++; if (busy !== 1'b0 || grant_id !== 1'b0) begin errors++; $display("FAIL reset_busy_gid: got %0h/%0h exp 0/0", busy, grant_id); end
        checks++; if (drop_count !== 16'd0 || timeout_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0h/%0h exp 0/0", drop_count, timeout_count); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h/%0h exp 0/0", req0_ready, req1_ready); end
    endtask

    task automatic test_single_burst();
        do_reset();
        req0_valid = 1'b1; req0_address = 32'd0; req0_data = 32'hC0DE_0000; req0_last = 1'b0;
        step();
        checks++; if (busy !== 1'b1 || grant_id !== 1'b0 || ctrl_write_en !== 1'b0) begin
            errors++; $display("FAIL burst_grant: busy/gid/we got %0h/%0h/%0h exp 1/0/0", busy, grant_id, ctrl_write_en); end
        for (int unsigned i = 0; i < 12; i++) begin
            req0_address = i; req0_data = 32'hC0DE_0000 + i; req0_last = (i == 11);
            #0;
            checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
                errors++; $display("FAIL burst_ready%0d: got %0h/%0h exp 1/0", i, req0_ready, req1_ready); end
            step();
            checks++; if (ctrl_write_en !== 1'b1 || ctrl_address !== i || ctrl_write_data !== 32'hC0DE_0000 + i) begin
                errors++; $display("FAIL burst_write%0d: we/addr/data got %0h/%0h/%0h exp 1/%0h/%0h",
                                   i, ctrl_write_en, ctrl_address, ctrl_write_data, i, 32'hC0DE_0000 + i); end
        end
        req0_valid = 1'b0; req0_last = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst_idle: busy got %0h exp 0", busy); end
        step();
        checks++; if (ctrl_write_en !== 1'b0) begin errors++; $display("FAIL burst_we_end: got %0h exp 0", ctrl_write_en); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0a [6]  = '{1, 2, 3, 7, 8, 9};
        logic        exp_we [13] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        logic        exp_bz [13] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0};
        logic        exp_gd [13] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [31:0] exp_a  [13] = '{0, 0, 1, 2, 3, 0, 4, 5, 6, 0, 7, 8, 9};
        logic [31:0] exp_d  [13] = '{0, 0, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 0,
                                     32'hB000_0004, 32'hB000_0005, 32'hB000_0006, 0,
                                     32'hA000_0007, 32'hA000_0008, 32'hA000_0009};
        int unsigned i0 = 0, i1 = 0;
        logic a0, a1;
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            req0_valid = (i0 < 6);
            req0_address = (i0 < 6) ? r0a[i0] : 32'd0;
            req0_data = 32'hA000_0000 | req0_address;
            req0_last = (i0 == 2 || i0 == 5);
            req1_valid = (i1 < 3);
            req1_address = 32'd4 + i1;
            req1_data = 32'hB000_0000 | req1_address;
            req1_last = (i1 == 2);
            #0;
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            step();
            if (a0) i0++;
            if (a1) i1++;
            checks++; if (busy !== exp_bz[k] || ctrl_write_en !== exp_we[k]) begin
                errors++; $display("FAIL b2b_state%0d: busy/we got %0h/%0h exp %0h/%0h", k, busy, ctrl_write_en, exp_bz[k], exp_we[k]); end
            if (exp_bz[k]) begin
                checks++; if (grant_id !== exp_gd[k]) begin
                    errors++; $display("FAIL b2b_gid%0d: got %0h exp %0h", k, grant_id, exp_gd[k]); end
            end
            if (exp_we[k]) begin
                checks++; if (ctrl_address !== exp_a[k] || ctrl_write_data !== exp_d[k]) begin
                    errors++; $display("FAIL b2b_write%0d: addr/data got %0h/%0h exp %0h/%0h", k, ctrl_address, ctrl_write_data, exp_a[k], exp_d[k]); end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_drops();
        logic [31:0] addrs [3] = '{32'd11, 32'd12, 32'hFFFF_FFFF};
        logic        exp_we [3] = '{1, 0, 0};
        logic [15:0] exp_dc [3] = '{0, 1, 2};
        do_reset();
        req0_valid = 1'b1; req0_address = addrs[0]; req0_data = 32'h5500_0011; req0_last = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            req0_address = addrs[i]; req0_data = 32'h5500_0000 + i + 32'h11; req0_last = (i == 2);
            step();
            checks++; if (ctrl_write_en !== exp_we[i] || drop_count !== exp_dc[i] || ctrl_address !== 32'd11 || ctrl_write_data !== 32'h5500_0011) begin
                errors++; $display("FAIL drop%0d: we/dc/addr/data got %0h/%0h/%0h/%0h exp %0h/%0h/b/5500_0011",
                                   i, ctrl_write_en, drop_count, ctrl_address, ctrl_write_data, exp_we[i], exp_dc[i]); end
        end
        req0_valid = 1'b0; req0_last = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_end: busy got %0h exp 0", busy); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        do_reset();
        ctrl_ready = 1'b0;
        req0_valid = 1'b1; req0_address = 32'd5; req0_data = 32'h0BAD_F00D; req0_last = 1'b1;
        step();
        for (int i = 0; i < 5000; i++) begin
            step();
            if (busy !== 1'b1 || ctrl_write_en !== 1'b0 || timeout_count !== 16'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: bad cycles got %0d exp 0", bad); end
        ctrl_ready = 1'b1;
        step();
        req0_valid = 1'b0; req0_last = 1'b0;
        checks++; if (ctrl_write_en !== 1'b1 || ctrl_address !== 32'd5 || ctrl_write_data !== 32'h0BAD_F00D || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release: we/addr/data/busy got %0h/%0h/%0h/%0h exp 1/5/0badf00d/0",
                               ctrl_write_en, ctrl_address, ctrl_write_data, busy); end
    endtask

    task automatic test_timeout();
        do_reset();
        req1_valid = 1'b1; req1_address = 32'd2; req1_data = 32'h1111_2222; req1_last = 1'b0;
        step();
        checks++; if (grant_id !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL to_grant: gid/busy got %0h/%0h exp 1/1", grant_id, busy); end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_address = 32'd3; req0_data = 32'h3333_4444; req0_last = 1'b1;
        #0;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL to_ng_ready: got %0h exp 0", req0_ready); end
        for (int s = 1; s <= 16; s++) begin
            step();
            if (s < 16) begin
                checks++; if (busy !== 1'b1 || timeout_count !== 16'd0) begin
                    errors++; $display("FAIL to_stall%0d: busy/tc got %0h/%0h exp 1/0", s, busy, timeout_count); end
            end else begin
                checks++; if (busy !== 1'b0 || timeout_count !== 16'd1) begin
                    errors++; $display("FAIL to_revoke: busy/tc got %0h/%0h exp 0/1", busy, timeout_count); end
            end
        end
        step();
        checks++; if (busy !== 1'b1 || grant_id !== 1'b0) begin
            errors++; $display("FAIL to_regrant: busy/gid got %0h/%0h exp 1/0", busy, grant_id); end
        step();
        req0_valid = 1'b0; req0_last = 1'b0;
        checks++; if (ctrl_write_en !== 1'b1 || ctrl_address !== 32'd3) begin
            errors++; $display("FAIL to_req0_write: we/addr got %0h/%0h exp 1/3", ctrl_write_en, ctrl_address); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // a completed req0 burst leaves the pointer favouring req1
        req0_valid = 1'b1; req0_address = 32'd0; req0_data = 32'h1; req0_last = 1'b1;
        step();
        step();
        req0_valid = 1'b0; req0_last = 1'b0;
        step();
        req0_valid = 1'b1; req0_address = 32'd0; req0_data = 32'h7700_0000;
        step();
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            req0_address = i + 1; req0_data = 32'h7700_0000 + i + 1;
        end
        ctrl_reset = 1'b1;
        step();
        ctrl_reset = 1'b0; req0_valid = 1'b0;
        checks++; if (ctrl_write_en !== 1'b0 || ctrl_address !== 32'd0 || ctrl_write_data !== 32'd0 || busy !== 1'b0 || grant_id !== 1'b0) begin
            errors++; $display("FAIL mid_reset: we/addr/data/busy/gid got %0h/%0h/%0h/%0h/%0h exp all 0",
                               ctrl_write_en, ctrl_address, ctrl_write_data, busy, grant_id); end
        step();
        checks++; if (ctrl_write_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_quiet: we/busy got %0h/%0h exp 0/0", ctrl_write_en, busy); end
        req0_valid = 1'b1; req0_address = 32'd1; req0_last = 1'b1;
        req1_valid = 1'b1; req1_address = 32'd2; req1_last = 1'b1;
        step();
        checks++; if (busy !== 1'b1 || grant_id !== 1'b0) begin
            errors++; $display("FAIL mid_reset_prio: busy/gid got %0h/%0h exp 1/0", busy, grant_id); end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_drops();
        test_backpressure();
        test_timeout();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neopixel_ctrl_arbiter.md
# neopixel_ctrl_arbiter

Shares the single neopixel control write port (`ctrl_write_en` / `ctrl_address` / `ctrl_write_data` / `ctrl_ready`) between two requesters, e.g. the AXI FIFO drain path and an on-chip pattern generator. Grants are burst-granular: a requester holds the port until it presents `last`, so pixel frames are never interleaved. Round-robin priority applies between bursts. Out-of-range pixel addresses are dropped and counted, and a stalled burst is forcibly released after a timeout.

## Interface
- `C_PIXELS`, 12: number of pixels. Valid addresses are 0 .. C_PIXELS-1.
- `C_TIMEOUT`, 1024: idle cycles allowed inside a granted burst before the grant is revoked (≥2).
- `ctrl_clock`  in  1  sole clock; all logic on rising edge.
- `ctrl_reset`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester N presents a write.
- `req0_address`, `req1_address`  in  32  pixel index.
- `req0_data`, `req1_data`  in  32  pixel colour word, passed through unmodified.
- `req0_last`, `req1_last`  in  1  this write ends requester N's burst.
- `req0_ready`, `req1_ready`  out  1  accept strobe. Combinational from state, grant and `ctrl_ready`.
- `ctrl_write_en`  out  1  single-cycle write pulse to the neopixel buffer.
- `ctrl_address`  out  32  registered address.
- `ctrl_write_data`  out  32  registered data.
- `ctrl_ready`  in  1  neopixel buffer can accept a write this cycle.
- `grant_id`  out  1  requester currently or last granted.
- `busy`  out  1  high in BURST state.
- `drop_count`  out  16  saturating count of out-of-range writes.
- `timeout_count`  out  16  saturating count of revoked bursts.

## Operation
- States: IDLE, BURST.
- IDLE:
  - If any `reqN_valid` is high, register the grant and go to BURST next cycle.
  - If both are valid, the requester with round-robin priority wins.
  - Priority pointer after reset: req0.
- BURST, accept rule:
  - `reqG_ready = busy & ctrl_ready`, where G = `grant_id`.
  - The non-granted `ready` is 0.
  - An accept is `reqG_valid & reqG_ready`.
- On an accept with `address < C_PIXELS` (unsigned 32-bit compare):
  - Next cycle `ctrl_write_en` = 1, `ctrl_address` = address, `ctrl_write_data` = data.
- On an accept with `address ≥ C_PIXELS`:
  - No `ctrl_write_en`; `ctrl_address`/`ctrl_write_data` hold.
  - `drop_count` += 1, saturating at 16'hFFFF.
- On an accept with `last` = 1 (in range or not):
  - Go to IDLE next cycle.
  - Priority pointer moves to the other requester.
- Timeout counter:
  - Clears on entering BURST and on every accept.
  - Increments each BURST cycle with `reqG_valid` = 0.
  - Holds while `reqG_valid` = 1 and `ctrl_ready` = 0; backpressure is not a stall.
  - On reaching C_TIMEOUT: go to IDLE, `timeout_count` += 1 (saturating), pointer moves to the other requester.
- Accept and timeout cannot coincide, because the counter clears on an accept.
- `ctrl_write_en` is never high for two consecutive cycles from one accept. Back-to-back accepts produce back-to-back pulses.

## Timing
- Reset:
  - Takes effect on the first rising edge with `ctrl_reset` = 1.
  - Next cycle: state IDLE; `ctrl_write_en`, `ctrl_address`, `ctrl_write_data`, `grant_id`, `busy`, `drop_count`, `timeout_count` all 0; `reqN_ready` 0; pointer = req0.
  - Reset in the middle of a burst abandons it; no further `ctrl_write_en`.
- Grant latency: `valid` rising in IDLE at cycle T gives `busy` = 1 and `ready` possible at T+1.
- Write latency: an accept at cycle T gives `ctrl_write_en` at T+1.
- Throughput:
  - One write per cycle inside a burst while `ctrl_ready` = 1.
  - One dead IDLE cycle between bursts.
  - A single-write burst (`last` on the first write) costs 2 cycles.
- Timeout: the last stall cycle is the C_TIMEOUT-th; state is IDLE the following cycle.
- `drop_count` and `timeout_count` update the cycle after the causing event.

## Test plan
- Single requester, burst of 12 writes to addresses 0..11 with `last` on 11, `ctrl_ready` = 1 → 12 consecutive `ctrl_write_en` pulses starting 2 cycles after the first `valid`; addresses and data match; back to IDLE.
- Both requesters valid from reset with 3-write bursts → order is req0 burst, req1 burst, req0 burst; writes never interleave within a burst; `grant_id` toggles.
- req0 writes addresses 11, 12, 0xFFFF_FFFF(`last`) with C_PIXELS = 12 → one `ctrl_write_en` (address 11); `drop_count` = 2; burst ends.
- `ctrl_ready` held low for 5000 cycles while req0 stays valid (C_TIMEOUT = 1024) → no timeout, no write; after `ctrl_ready` rises the write completes.
- req1 granted, then drops `valid` mid-burst with C_TIMEOUT = 16 → IDLE after the 16th stall cycle; `timeout_count` = 1; a pending req0 is granted next.
- Assert `ctrl_reset` for 1 cycle at burst write 5 of 12 → all outputs 0 next cycle; no further writes; next grant goes to req0.
